// File: rtl/spike_pattern_decoder_pkg.sv
// Shared definitions for the Hopfield readout path: decoder state encoding
// and default sizing, also used by the network's top-level wrapper.
package spike_pattern_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int DEF_N      = 7;
    localparam int DEF_NOUT   = 4;
    localparam int DEF_CW     = 8;
    localparam int DEF_THRESH = 4;
    localparam int DEF_WINDOW = 256;
    localparam int DEF_SETTLE = 16;

    // Width of a down-counter that must hold the value n (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spike_pattern_decoder_edge_counter.sv
// Per-neuron rising-edge spike counter with saturation; prev tracks the
// spike line every cycle regardless of enable.
module spike_edge_counter
    import spike_pattern_decoder_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spike,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count_next
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          prev_reg;
    logic [CW-1:0] count_reg;
    logic          rise;

    assign rise = spike & ~prev_reg;

    // Exposed combinationally so the window decision sees the final cycle's edge.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && rise && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            prev_reg  <= spike;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/spike_pattern_decoder.sv
// Hopfield readout: counts spike edges per neuron over a fixed window and
// thresholds them into a recalled pattern. Optional SPIKE_DECODER_SETTLE_EN.
module spike_pattern_decoder
    import spike_pattern_decoder_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int NOUT   = DEF_NOUT,
    parameter int WINDOW = DEF_WINDOW,
    parameter int CW     = DEF_CW,
    parameter int THRESH = DEF_THRESH
`ifdef SPIKE_DECODER_SETTLE_EN
    ,
    parameter int SETTLE = DEF_SETTLE
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    spikes,
    input  logic            start,
    output logic [NOUT-1:0] pattern_out,
    output logic            pattern_valid,
    input  logic            pattern_ready,
    output logic            silent,
    output logic            busy
);

    localparam int            WCW      = cnt_width(WINDOW);
    localparam logic [WCW-1:0] WIN_LOAD = WCW'(WINDOW);
    localparam logic [CW-1:0]  THR      = CW'(THRESH);

`ifdef SPIKE_DECODER_SETTLE_EN
    localparam int             SCW         = cnt_width(SETTLE);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE);
    logic [SCW-1:0] settle_cnt_reg;
`endif

    state_t          state_reg;
    logic [WCW-1:0]  win_cnt_reg;
    logic [NOUT-1:0] pattern_out_reg;
    logic            pattern_valid_reg;
    logic            silent_reg;
    logic            busy_reg;

    logic            clear_cnt;
    logic            count_en;
    logic [CW-1:0]   cnt_next [N];
    logic [N-1:0]    nonzero;
    logic [NOUT-1:0] decoded;

    assign clear_cnt = (state_reg == ST_IDLE) && start;
    assign count_en  = (state_reg == ST_COUNT);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_neuron
            spike_edge_counter #(
                .CW (CW)
            ) u_cnt (
                .clk        (clk),
                .reset_n    (reset_n),
                .spike      (spikes[gi]),
                .clear      (clear_cnt),
                .enable     (count_en),
                .count_next (cnt_next[gi])
            );
            assign nonzero[gi] = |cnt_next[gi];
        end

        for (genvar gi = 0; gi < NOUT; gi++) begin : g_decode
            assign decoded[gi] = (cnt_next[gi] >= THR);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            win_cnt_reg       <= '0;
            pattern_out_reg   <= '0;
            pattern_valid_reg <= 1'b0;
            silent_reg        <= 1'b1;
            busy_reg          <= 1'b0;
`ifdef SPIKE_DECODER_SETTLE_EN
            settle_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
`ifdef SPIKE_DECODER_SETTLE_EN
                        if (SETTLE == 0) begin
                            state_reg   <= ST_COUNT;
                            win_cnt_reg <= WIN_LOAD;
                        end else begin
                            state_reg      <= ST_SETTLE;
                            settle_cnt_reg <= SETTLE_LOAD;
                        end
`else
                        state_reg   <= ST_COUNT;
                        win_cnt_reg <= WIN_LOAD;
`endif
                    end
                end
`ifdef SPIKE_DECODER_SETTLE_EN
                ST_SETTLE: begin
                    if (settle_cnt_reg == SCW'(1)) begin
                        state_reg   <= ST_COUNT;
                        win_cnt_reg <= WIN_LOAD;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SCW'(1);
                    end
                end
`endif
                ST_COUNT: begin
                    // Last window cycle: latch the decision including this cycle's edges.
                    if (win_cnt_reg == WCW'(1)) begin
                        state_reg         <= ST_HOLD;
                        pattern_out_reg   <= decoded;
                        silent_reg        <= ~|nonzero;
                        pattern_valid_reg <= 1'b1;
                    end else begin
                        win_cnt_reg <= win_cnt_reg - WCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (pattern_ready) begin
                        state_reg         <= ST_IDLE;
                        pattern_valid_reg <= 1'b0;
                        busy_reg          <= 1'b0;
                    end
                end
                default: begin
                    state_reg         <= ST_IDLE;
                    pattern_valid_reg <= 1'b0;
                    busy_reg          <= 1'b0;
                end
            endcase
        end
    end

    assign pattern_out   = pattern_out_reg;
    assign pattern_valid = pattern_valid_reg;
    assign silent        = silent_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Randomized bench for spike_pattern_decoder: two instances (CW=8/THRESH=4 and
// CW=4/THRESH=15) checked against an edge-counting reference model.
module tb_spike_pattern_decoder;

    localparam int WIN = 256;
`ifdef SPIKE_DECODER_SETTLE_EN
    localparam int S = 16;
`else
    localparam int S = 0;
`endif
    localparam int LAST = S + WIN;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] spikes = '0;
    logic       start = 1'b0;
    logic       pattern_ready = 1'b0;

    logic [3:0] a_pattern_out, b_pattern_out;
    logic       a_valid, b_valid, a_silent, b_silent, a_busy, b_busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] pat [0:LAST];
    logic [3:0] exp_po_a, exp_po_b;
    logic       exp_sil_a, exp_sil_b;

    always #5 clk = ~clk;

    spike_pattern_decoder #(
        .N(7), .NOUT(4), .WINDOW(WIN), .CW(8), .THRESH(4)
`ifdef SPIKE_DECODER_SETTLE_EN
        , .SETTLE(S)
`endif
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .spikes(spikes), .start(start),
        .pattern_out(a_pattern_out), .pattern_valid(a_valid),
        .pattern_ready(pattern_ready), .silent(a_silent), .busy(a_busy)
    );

    spike_pattern_decoder #(
        .N(7), .NOUT(4), .WINDOW(WIN), .CW(4), .THRESH(15)
`ifdef SPIKE_DECODER_SETTLE_EN
        , .SETTLE(S)
`endif
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .spikes(spikes), .start(start),
        .pattern_out(b_pattern_out), .pattern_valid(b_valid),
        .pattern_ready(pattern_ready), .silent(b_silent), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Count rising edges (high now, low the cycle before) over the counting
    // cycles, clamp to the counter range, then threshold.
    task automatic model(input int cw, input int thr, output logic [3:0] po, output logic sil);
        int cnt;
        po  = '0;
        sil = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cnt = 0;
            for (int c = S + 1; c <= LAST; c++)
                if (pat[c][k] && !pat[c-1][k]) cnt++;
            if (cnt > (1 << cw) - 1) cnt = (1 << cw) - 1;
            if (cnt != 0) sil = 1'b0;
            if (k < 4 && cnt >= thr) po[k] = 1'b1;
        end
    endtask

    task automatic gen(input int mode);
        int p;
        for (int c = 0; c <= LAST; c++) pat[c] = '0;
        for (int c = 1; c <= S; c++) pat[c] = 7'($urandom);
        case (mode)
            0: for (int i = 0; i < 10; i++) begin
                p = S + 2 + 25 * i + int'($urandom_range(0, 19));
                pat[p][0] = 1'b1;
                p = S + 2 + 25 * i + int'($urandom_range(0, 19));
                pat[p][2] = 1'b1;
            end
            1: ;
            2: for (int i = 0; i < 3; i++) begin
                p = S + 2 + 80 * i + int'($urandom_range(0, 70));
                pat[p][5] = 1'b1;
            end
            3: for (int c = 0; c <= LAST; c++) begin
                pat[c][1] = 1'b1;
                if (c > S) pat[c][3] = c[0];
            end
            default: for (int c = S + 1; c <= LAST; c++)
                for (int k = 0; k < 7; k++)
                    pat[c][k] = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid_a"}, a_valid, 0);
        check({tag, "_busy_a"}, a_busy, 0);
        check({tag, "_silent_a"}, a_silent, 1);
        check({tag, "_pat_a"}, a_pattern_out, 0);
        check({tag, "_valid_b"}, b_valid, 0);
        check({tag, "_busy_b"}, b_busy, 0);
        check({tag, "_silent_b"}, b_silent, 1);
        check({tag, "_pat_b"}, b_pattern_out, 0);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid_a"}, a_valid, 1);
        check({tag, "_busy_a"}, a_busy, 1);
        check({tag, "_pat_a"}, a_pattern_out, exp_po_a);
        check({tag, "_silent_a"}, a_silent, exp_sil_a);
        check({tag, "_valid_b"}, b_valid, 1);
        check({tag, "_pat_b"}, b_pattern_out, exp_po_b);
        check({tag, "_silent_b"}, b_silent, exp_sil_b);
    endtask

    // Cycle 0 carries start; cycles 1..S settle, S+1..S+WIN count; the
    // result must appear in cycle S+WIN+1. rst_at < 0 disables the reset hit.
    task automatic do_decode(input int mode, input int rdy_delay, input bit start_on_xfer, input int rst_at);
        int fails_before;
        fails_before = tests_failed;
        gen(mode);
        model(8, 4, exp_po_a, exp_sil_a);
        model(4, 15, exp_po_b, exp_sil_b);

        @(posedge clk); #1;
        start = 1'b1;
        spikes = pat[0];
        pattern_ready = (rdy_delay == 0);
        for (int c = 1; c <= LAST; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 15) == 0);
            spikes = pat[c];
            if (c == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_vals("midreset");
                @(posedge clk); #1;
                reset_n = 1'b1;
                start = 1'b0;
                $display("[TB] decode mode=%0d reset at cycle %0d, %0d new fails", mode, c, tests_failed - fails_before);
                return;
            end
            @(negedge clk);
            check("count_busy", a_busy & b_busy, 1);
            check("count_valid", a_valid | b_valid, 0);
        end

        @(posedge clk); #1;
        spikes = 7'($urandom);
        start = (rdy_delay == 0) ? start_on_xfer : 1'($urandom);
        @(negedge clk);
        check_result("result");

        for (int h = 1; h <= rdy_delay; h++) begin
            @(posedge clk); #1;
            pattern_ready = (h == rdy_delay);
            spikes = 7'($urandom);
            start = (h == rdy_delay) ? start_on_xfer : 1'($urandom);
            @(negedge clk);
            check_result("hold");
        end

        @(posedge clk); #1;
        start = 1'b0;
        pattern_ready = 1'b0;
        @(negedge clk);
        check("xfer_valid_a", a_valid, 0);
        check("xfer_busy_a", a_busy, 0);
        check("xfer_busy_b", b_busy, 0);
        check("xfer_keep_pat_a", a_pattern_out, exp_po_a);
        check("xfer_keep_sil_b", b_silent, exp_sil_b);
        $display("[TB] decode mode=%0d rdy_delay=%0d start_on_xfer=%0d exp_a=%b/%0d exp_b=%b/%0d, %0d new fails",
                 mode, rdy_delay, start_on_xfer, exp_po_a, exp_sil_a, exp_po_b, exp_sil_b,
                 tests_failed - fails_before);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("idle");

        do_decode(0, 0, 1'b0, -1);
        do_decode(1, 3, 1'b1, -1);
        do_decode(2, 1, 1'b0, -1);
        do_decode(3, 20, 1'b1, -1);
        do_decode(0, 2, 1'b0, S + 100);
        do_decode(0, 0, 1'b1, -1);
        for (int i = 0; i < 6; i++)
            do_decode(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom), -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
